// File: rtl/os_drain_pkg.sv
// Shared types and sizing helpers for the output-stationary result drain.
package os_drain_pkg;

   // Drain sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      FINISH = 2'd2
   } drain_state_t;

   // Row index width: max(1, $clog2(rows)) so a single-row array still has a 1-bit index.
   function automatic int row_idx_w_f(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/sat_narrow.sv
// Narrows one signed accumulator to the result width, clamping at the signed limits.
module sat_narrow #(
   parameter int in_w  = 48,
   parameter int out_w = 32
) (
   input  logic signed [in_w-1:0]  din,
   output logic signed [out_w-1:0] dout,
   output logic                    sat
);

   generate
      if (in_w == out_w) begin : g_pass
         assign dout = din;
         assign sat  = 1'b0;
      end else begin : g_sat
         // Returns {sat, value}. The value fits when every bit from the result sign bit
         // upward is a copy of the input sign bit.
         function automatic logic [out_w:0] narrow(input logic signed [in_w-1:0] v);
            logic [in_w-out_w:0] top;
            top = v[in_w-1:out_w-1];
            if ((top == '0) || (top == '1))
               return {1'b0, v[out_w-1:0]};
            else if (v[in_w-1])
               return {1'b1, 1'b1, {(out_w-1){1'b0}}};
            else
               return {1'b1, 1'b0, {(out_w-1){1'b1}}};
         endfunction

         assign {sat, dout} = narrow(din);
      end
   endgenerate

endmodule

// File: rtl/os_result_drain.sv
// Streams the accumulators of an output-stationary array out one saturated row per beat.
module os_result_drain
   import os_drain_pkg::*;
#(
   parameter int rows      = 64,
   parameter int cols      = 64,
   parameter int op_width  = 48,
   parameter int res_width = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               compute_done,
   input  logic [rows*cols*op_width-1:0]      acc_matrix,
   output logic                               hold,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [cols*res_width-1:0]          out_data,
   output logic [row_idx_w_f(rows)-1:0]       out_row,
   output logic                               out_last,
   output logic                               out_sat,
   output logic                               drain_done
);

   localparam int row_idx_w = row_idx_w_f(rows);
   localparam int row_bits  = cols * op_width;
   localparam logic [row_idx_w-1:0] last_row = row_idx_w'(rows - 1);

   drain_state_t               state_q;
   logic                       done_q;
   logic                       armed_q;
   logic                       out_valid_q;
   logic [cols*res_width-1:0]  out_data_q;
   logic [row_idx_w-1:0]       row_q;
   logic [row_idx_w-1:0]       row_d;
   logic                       out_last_q;
   logic                       out_sat_q;
   logic                       drain_done_q;

   logic                       start;
   logic                       accept;
   logic                       at_last;
   logic [31:0]                sel_base;
   logic [row_bits-1:0]        sel_vec;
   logic [cols*res_width-1:0]  nar_row;
   logic [cols-1:0]            nar_sat;

   // armed_q blocks a compute_done level that survived reset from looking like a new
   // rising edge; it only arms once compute_done has been seen low.
   assign start   = compute_done & ~done_q & armed_q;
   assign accept  = out_valid_q & out_ready;
   assign at_last = (row_q == last_row);
   assign hold    = (state_q != IDLE) | start;

   // Row to present next: row 0 on a start, otherwise the successor of the current row.
   always_comb begin
      row_d = '0;
      if ((state_q == DRAIN) && !at_last)
         row_d = row_q + 1'b1;
   end

   // The selected row is read straight out of the live accumulator bus.
   assign sel_base = 32'(row_d) * 32'(row_bits);
   assign sel_vec  = acc_matrix[sel_base +: row_bits];

   generate
      for (genvar j = 0; j < cols; j++) begin : g_col
         sat_narrow #(
            .in_w  (op_width),
            .out_w (res_width)
         ) u_sat (
            .din  (sel_vec[j*op_width +: op_width]),
            .dout (nar_row[j*res_width +: res_width]),
            .sat  (nar_sat[j])
         );
      end
   endgenerate

   // Edge detection on compute_done and post-reset arming.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         done_q  <= compute_done;
         armed_q <= armed_q | ~compute_done;
      end
   end

   // Drain sequencer with registered beat outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         row_q        <= '0;
         out_last_q   <= 1'b0;
         out_sat_q    <= 1'b0;
         drain_done_q <= 1'b0;
      end else begin
         drain_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= DRAIN;
                  out_valid_q <= 1'b1;
                  out_data_q  <= nar_row;
                  row_q       <= row_d;
                  out_last_q  <= (row_d == last_row);
                  out_sat_q   <= |nar_sat;
               end
            end
            DRAIN: begin
               if (accept) begin
                  if (at_last) begin
                     state_q      <= FINISH;
                     out_valid_q  <= 1'b0;
                     out_last_q   <= 1'b0;
                     drain_done_q <= 1'b1;
                  end else begin
                     out_data_q <= nar_row;
                     row_q      <= row_d;
                     out_last_q <= (row_d == last_row);
                     out_sat_q  <= |nar_sat;
                  end
               end
            end
            FINISH: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_row    = row_q;
   assign out_last   = out_last_q;
   assign out_sat    = out_sat_q;
   assign drain_done = drain_done_q;

endmodule

// File: tb/tb_os_result_drain.sv
// Scoreboard bench for os_result_drain with a 4x4 array and 48->16 bit saturation.
module tb_os_result_drain;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int OPW  = 48;
   localparam int RESW = 16;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      compute_done;
   logic [ROWS*COLS*OPW-1:0]  acc_matrix;
   logic                      hold;
   logic                      out_valid;
   logic                      out_ready;
   logic [COLS*RESW-1:0]      out_data;
   logic [1:0]                out_row;
   logic                      out_last;
   logic                      out_sat;
   logic                      drain_done;

   always #5 clk = ~clk;

   os_result_drain #(
      .rows      (ROWS),
      .cols      (COLS),
      .op_width  (OPW),
      .res_width (RESW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .compute_done (compute_done),
      .acc_matrix   (acc_matrix),
      .hold         (hold),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_row      (out_row),
      .out_last     (out_last),
      .out_sat      (out_sat),
      .drain_done   (drain_done)
   );

   typedef struct packed {
      logic [1:0]  row;
      logic [63:0] data;
      logic        last;
      logic        sat;
   } beat_t;

   beat_t   exp_q[$];
   beat_t   mon_b;
   int      checks     = 0;
   int      errors     = 0;
   int      accepts    = 0;
   int      dd_seen    = 0;
   logic    dd_pending = 1'b0;
   longint  C [ROWS][COLS];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input longint v);
      logic [63:0] t;
      if (v > 32767)       return 16'h7fff;
      else if (v < -32768) return 16'h8000;
      t = v;
      return t[15:0];
   endfunction

   task automatic load_matrix();
      logic [63:0] t;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) begin
            t = C[i][j];
            acc_matrix[(i*COLS+j)*OPW +: OPW] = t[OPW-1:0];
         end
   endtask

   task automatic push_drain();
      beat_t b;
      for (int r = 0; r < ROWS; r++) begin
         b.row  = r[1:0];
         b.last = (r == ROWS-1);
         b.sat  = 1'b0;
         for (int j = 0; j < COLS; j++) begin
            b.data[j*RESW +: RESW] = sat16(C[r][j]);
            if (C[r][j] > 32767 || C[r][j] < -32768) b.sat = 1'b1;
         end
         exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_dd(input int target);
      int n = 0;
      while (dd_seen < target && n < 60) begin
         tick();
         n++;
      end
      chk("drain_done_within_budget", 64'(dd_seen >= target), 64'd1);
   endtask

   // Monitor: compares every presented beat with the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         if (dd_pending) begin
            chk("drain_done_after_last", 64'(drain_done), 64'd1);
            chk("hold_in_finish", 64'(hold), 64'd1);
            chk("valid_low_in_finish", 64'(out_valid), 64'd0);
            dd_pending = 1'b0;
         end else if (drain_done) begin
            chk("unexpected_drain_done", 64'(drain_done), 64'd0);
         end
         if (drain_done) dd_seen++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
               mon_b = exp_q[0];
               chk("beat_row",  64'(out_row),  64'(mon_b.row));
               chk("beat_data", out_data,      mon_b.data);
               chk("beat_last", 64'(out_last), 64'(mon_b.last));
               chk("beat_sat",  64'(out_sat),  64'(mon_b.sat));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  accepts++;
                  if (mon_b.last) dd_pending = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int pat [6] = '{1, 0, 0, 1, 0, 1};
      int k;

      rst          = 1'b1;
      compute_done = 1'b0;
      out_ready    = 1'b0;
      acc_matrix   = '0;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            C[i][j] = 0;
      #2;
      chk("rst_valid", 64'(out_valid),  64'd0);
      chk("rst_data",  out_data,        64'd0);
      chk("rst_row",   64'(out_row),    64'd0);
      chk("rst_last",  64'(out_last),   64'd0);
      chk("rst_sat",   64'(out_sat),    64'd0);
      chk("rst_done",  64'(drain_done), 64'd0);
      chk("rst_hold",  64'(hold),       64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Ramp matrix, ready held high.
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            C[i][j] = i*4 + j;
      load_matrix();
      push_drain();
      out_ready    = 1'b1;
      compute_done = 1'b1;
      #1;
      chk("hold_start_cycle", 64'(hold), 64'd1);
      chk("valid_before_start", 64'(out_valid), 64'd0);
      tick();
      chk("first_beat_latency", 64'(out_valid), 64'd1);
      chk("first_beat_row", 64'(out_row), 64'd0);
      chk("hold_in_drain", 64'(hold), 64'd1);
      compute_done = 1'b0;
      tick();
      tick();
      chk("row2_index", 64'(out_row), 64'd2);
      chk("row2_data", out_data, {16'd11, 16'd10, 16'd9, 16'd8});
      chk("row2_not_last", 64'(out_last), 64'd0);
      wait_dd(1);
      tick();
      chk("hold_idle", 64'(hold), 64'd0);
      chk("valid_idle", 64'(out_valid), 64'd0);
      chk("accepts_basic", 64'(accepts), 64'd4);
      chk("queue_empty_basic", 64'(exp_q.size()), 64'd0);

      // Saturating elements in rows 1 and 3.
      C[1][2] = 40000;
      C[3][0] = -40000;
      load_matrix();
      push_drain();
      compute_done = 1'b1;
      tick();
      compute_done = 1'b0;
      wait_dd(2);
      tick();
      chk("accepts_sat", 64'(accepts), 64'd8);

      // Ready toggling, plus a second compute_done edge mid-drain.
      push_drain();
      compute_done = 1'b1;
      out_ready    = 1'b1;
      tick();
      k = 0;
      while (dd_seen < 3 && k < 60) begin
         out_ready    = pat[k % 6][0];
         compute_done = (k == 2);
         tick();
         k++;
      end
      compute_done = 1'b0;
      out_ready    = 1'b1;
      chk("accepts_toggle", 64'(accepts), 64'd12);
      repeat (5) tick();
      chk("no_restart_after_toggle", 64'(out_valid), 64'd0);
      chk("single_done_toggle", 64'(dd_seen), 64'd3);

      // Reset while row 1 is presented, compute_done kept high.
      push_drain();
      out_ready    = 1'b1;
      compute_done = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      chk("pre_reset_row", 64'(out_row), 64'd1);
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data",  out_data,       64'd0);
      chk("mid_rst_row",   64'(out_row),   64'd0);
      chk("mid_rst_last",  64'(out_last),  64'd0);
      chk("mid_rst_sat",   64'(out_sat),   64'd0);
      chk("mid_rst_hold",  64'(hold),      64'd0);
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("no_restart_level", 64'(out_valid), 64'd0);
      chk("no_hold_level", 64'(hold), 64'd0);
      chk("no_done_after_rst", 64'(dd_seen), 64'd3);
      compute_done = 1'b0;
      tick();
      tick();
      push_drain();
      out_ready    = 1'b1;
      compute_done = 1'b1;
      #1;
      chk("hold_fresh_start", 64'(hold), 64'd1);
      tick();
      chk("fresh_first_valid", 64'(out_valid), 64'd1);
      chk("fresh_first_row", 64'(out_row), 64'd0);
      compute_done = 1'b0;
      wait_dd(4);
      tick();
      chk("accepts_final", 64'(accepts), 64'd17);
      chk("queue_empty_final", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
